ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised iterative multiply/divide execute unit for the RV32M extension, sitting in the EX stage beside the single-cycle ALU. It accepts one operation per `start` pulse, computes over multiple cycles with a configurable number of result bits per cycle, and reports completion through a one-cycle `done` strobe. The EX stage treats `done` as its ALU-response stall release. Divide-by-zero and signed overflow take a fast path, and a pipeline `flush` cancels an operation in flight.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even and ≥ 8.
- `BITS_PER_CYCLE`, default 1: product or quotient bits retired per iteration. Legal values are 1, 2 and 4, and the value must divide `WIDTH`.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: launches an operation; sampled only in IDLE.
- `funct3` input 3: RV32M encoding.
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu
  - 100 div, 101 divu, 110 rem, 111 remu
- `a` input `WIDTH`: rs1 operand, already forwarded by the EX stage.
- `b` input `WIDTH`: rs2 operand, already forwarded by the EX stage.
- `flush` input 1: synchronous cancel.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle completion strobe.
- `result` output `WIDTH`: registered result. Holds its value until the next completion.

## Operation
- Let N = `WIDTH` / `BITS_PER_CYCLE`.
- States:
  - IDLE: `start`=1 and `flush`=0 latches `funct3`, `a` and `b`. Goes to SPECIAL if the operation is a divide/remainder with b==0 or with a signed overflow. Otherwise goes to CALC.
  - CALC: runs N iterations counted by a down-counter, then goes to FIN.
  - SPECIAL and FIN: each lasts one cycle. Loads `result`, pulses `done` and returns to IDLE.
- Operand magnitude:
  - Signed operands are converted to magnitude on entry.
  - mulh, div and rem treat both operands as signed. mulhsu treats a as signed and b as unsigned. mul, mulhu, divu and remu treat both as unsigned.
  - mul low bits are sign-independent.
- Multiply:
  - Shift-add over a 2·`WIDTH` accumulator, `BITS_PER_CYCLE` multiplier bits per iteration.
  - In FIN the full product is negated if the operand signs differ.
  - mul returns the low `WIDTH` bits. mulh, mulhsu and mulhu return the high `WIDTH` bits.
- Divide:
  - Restoring division, `BITS_PER_CYCLE` quotient bits per iteration.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- SPECIAL results:
  - Divide by zero: div and divu return all-ones. rem and remu return a.
  - Signed overflow (a = most-negative value, b = −1, div or rem only): div returns a, rem returns 0.
- `start` while `busy` is ignored. Operands are not re-sampled.
- `flush` in any non-IDLE state forces IDLE on the next edge and suppresses `done`. `result` is not updated.
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is launched.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, counter 0, `busy`=0, `done`=0, `result`=0.
- Reset asserted mid-operation aborts immediately, with no `done`.
- Normal latency, with `start` sampled at edge 0:
  - `busy` is high from edge 0 through edge N.
  - `done` is high for exactly one cycle, after edge N+1, with `result` valid in the same cycle.
  - `busy` is low whenever `done` is high.
- Fast path: `done` after edge 1. `busy` is high only in the cycle between edge 0 and edge 1.
- A new `start` is accepted in the same cycle `done` is high, since the state is IDLE. Back-to-back throughput is therefore one operation per N+2 cycles.
- Width rules:
  - Product accumulator is 2·`WIDTH`.
  - Partial remainder is `WIDTH`+1 bits.
  - Counter is ⌈log2(N+1)⌉ bits.

## Test plan
- mul a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` appears after edge 33 (`WIDTH`=32, `BITS_PER_CYCLE`=1) and lasts exactly one cycle.
- High-half multiplies:
  - mulh 0x80000000·0x80000000 → 0x40000000
  - mulhu 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE
  - mulhsu 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFF
- Divide and remainder:
  - div 0xFFFFFFF9/2 → 0xFFFFFFFD
  - rem 0xFFFFFFF9/2 → 0xFFFFFFFF
  - divu 0xFFFFFFFF/2 → 0x7FFFFFFF
  - remu 13/5 → 3
- Special cases, each with `done` after edge 1:
  - div 5/0 → 0xFFFFFFFF
  - rem 5/0 → 5
  - div 0x80000000/0xFFFFFFFF → 0x80000000
  - rem 0x80000000/0xFFFFFFFF → 0
- Flush and busy behaviour:
  - `flush` at edge 10 of a div → no `done`, `busy`=0 after edge 10, `result` unchanged.
  - `start` pulsed at edge 5 of a running operation → ignored.
  - A new mul started right after the flush completes correctly.
- Reset and `BITS_PER_CYCLE`=4:
  - Drop `rst` mid-CALC → all outputs 0 immediately, with no `done` after release.
  - With `BITS_PER_CYCLE`=4, mulhu 0xFFFFFFFF·0xFFFFFFFF gives `done` after edge 9 with 0xFFFFFFFE.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative
// multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per step.
module ex_muldiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave io
);

  localparam int W  = WIDTH;
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = W / B;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] N_CNT = CW'(N);
  localparam logic [W-1:0]  MINV  =
    {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SPECIAL,
    FIN
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W:0]     rem_q;
  logic [W-1:0]   opb;
  logic [2:0]     op_q;
  logic           neg_q;
  logic           neg_r;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   res_q;

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = res_q;

  logic         a_sgn;
  logic         b_sgn;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic         div_zero;
  logic         ovf;
  logic         special;
  logic [W-1:0] spec_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (io.funct3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & io.a[W-1];
    b_neg = b_sgn & io.b[W-1];
    mag_a = a_neg ? -io.a : io.a;
    mag_b = b_neg ? -io.b : io.b;
    div_zero = io.funct3[2] && (io.b == '0);
    ovf = io.funct3[2] && !io.funct3[0] &&
          (io.a == MINV) && (&io.b);
    special = div_zero || ovf;
    if (div_zero)
      spec_res = io.funct3[1] ? io.a : '1;
    else
      spec_res = io.funct3[1] ? '0 : io.a;
  end

  // Multiply step: low acc half holds the unretired multiplier bits.
  logic [B-1:0]     mbits;
  logic [W+B-1:0]   psum;
  logic [2*W+B-1:0] wide;
  logic [2*W-1:0]   mul_nxt;

  always_comb begin
    mbits   = acc[B-1:0];
    psum    = (W+B)'(acc[2*W-1:W]) +
              (W+B)'(mbits) * (W+B)'(opb);
    wide    = {psum, acc[W-1:0]};
    mul_nxt = (2*W)'(wide >> B);
  end

  // Divide step: dividend shifts out of acc low as quotient shifts in.
  logic [W:0]   r_t;
  logic [W:0]   r_sh;
  logic [W-1:0] q_t;

  always_comb begin
    r_t  = rem_q;
    r_sh = '0;
    q_t  = acc[W-1:0];
    for (int i = 0; i < B; i++) begin
      r_sh = (r_t << 1) | (W+1)'(q_t[W-1]);
      q_t  = q_t << 1;
      if (r_sh >= (W+1)'(opb)) begin
        r_t    = r_sh - (W+1)'(opb);
        q_t[0] = 1'b1;
      end else begin
        r_t = r_sh;
      end
    end
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rmd;
  logic [W-1:0]   fin_res;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rmd  = neg_r ? -rem_q[W-1:0] : rem_q[W-1:0];
    if (op_q[2])
      fin_res = op_q[1] ? rmd : quo;
    else if (op_q[1:0] == 2'b00)
      fin_res = prod[W-1:0];
    else
      fin_res = prod[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      rem_q  <= '0;
      opb    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (io.flush && state != IDLE) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (io.start && !io.flush) begin
              op_q   <= io.funct3;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              busy_q <= 1'b1;
              rem_q  <= '0;
              if (special) begin
                state <= SPECIAL;
                acc   <= {{W{1'b0}}, spec_res};
              end else begin
                state <= CALC;
                cnt   <= N_CNT;
                if (io.funct3[2]) begin
                  acc <= {{W{1'b0}}, mag_a};
                  opb <= mag_b;
                end else begin
                  acc <= {{W{1'b0}}, mag_b};
                  opb <= mag_a;
                end
              end
            end
          end
          CALC: begin
            if (op_q[2]) begin
              acc   <= {acc[2*W-1:W], q_t};
              rem_q <= r_t;
            end else begin
              acc <= mul_nxt;
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
              state <= FIN;
          end
          SPECIAL: begin
            res_q  <= acc[W-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          FIN: begin
            res_q  <= fin_res;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a result scoreboard;
// covers BITS_PER_CYCLE of 1 and 4.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        sel4;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  ex_muldiv_if #(.WIDTH(32)) i1 ();
  ex_muldiv_if #(.WIDTH(32)) i4 ();

  assign i1.start  = start & ~sel4;
  assign i1.flush  = flush & ~sel4;
  assign i1.funct3 = funct3;
  assign i1.a      = a;
  assign i1.b      = b;
  assign i4.start  = start & sel4;
  assign i4.flush  = flush & sel4;
  assign i4.funct3 = funct3;
  assign i4.a      = a;
  assign i4.b      = b;

  assign busy_o   = sel4 ? i4.busy : i1.busy;
  assign done_o   = sel4 ? i4.done : i1.done;
  assign result_o = sel4 ? i4.result : i1.result;

  ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .io(i1.slave)
  );

  ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .io(i4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
  } exp_t;

  exp_t        sbq[$];
  int          total;
  int          bad;
  logic [31:0] last_res;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [2:0] f,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input bit push,
                        input logic [31:0] expv,
                        input string tag);
    exp_t e;
    @(negedge clk);
    funct3 = f;
    a      = av;
    b      = bv;
    start  = 1'b1;
    if (push) begin
      e.tag = tag;
      e.res = expv;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, "_busy0"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat,
                           input int from_k,
                           input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int k = from_k + 1; k <= lat + 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        seen = 1'b1;
        e = sbq.pop_front();
        chk({e.tag, "_res"}, result_o, e.res);
        chk({e.tag, "_lat"}, 32'(k), 32'(lat));
        chk({e.tag, "_busy"}, 32'(busy_o), 32'd0);
        last_res = e.res;
        @(posedge clk);
        #1;
        chk({e.tag, "_strobe"}, 32'(done_o), 32'd0);
        chk({e.tag, "_hold"}, result_o, e.res);
      end else if (k < lat) begin
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(seen), 32'd1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
  endtask

  task automatic run(input logic [2:0] f,
                     input logic [31:0] av,
                     input logic [31:0] bv,
                     input logic [31:0] expv,
                     input int lat,
                     input string tag);
    launch(f, av, bv, 1'b1, expv, tag);
    wait_done(lat, 0, tag);
  endtask

  task automatic quiet(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    chk({tag, "_nodone"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] p;
    total    = 0;
    bad      = 0;
    last_res = '0;
    rst      = 1'b0;
    sel4     = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = '0;
    a        = '0;
    b        = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy1", 32'(i1.busy), 32'd0);
    chk("rst_done1", 32'(i1.done), 32'd0);
    chk("rst_res1", i1.result, 32'd0);
    chk("rst_busy4", 32'(i4.busy), 32'd0);
    chk("rst_res4", i4.result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run(3'b000, 32'd7, 32'hFFFF_FFFD,
        32'hFFFF_FFEB, 33, "mul");
    run(3'b001, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 33, "mulh");
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 33, "mulhu");
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 33, "mulhsu");
    run(3'b100, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 33, "div");
    run(3'b110, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 33, "rem");
    run(3'b101, 32'hFFFF_FFFF, 32'd2,
        32'h7FFF_FFFF, 33, "divu");
    run(3'b111, 32'd13, 32'd5, 32'd3, 33, "remu");

    launch(3'b100, 32'd100, 32'd7, 1'b0, '0, "fl");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk("fl_busy", 32'(busy_o), 32'd1);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("fl_busy_off", 32'(busy_o), 32'd0);
    chk("fl_done", 32'(done_o), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    quiet(40, "fl");
    chk("fl_res_hold", result_o, last_res);

    run(3'b000, 32'h0001_2345, 32'h10,
        32'h0012_3450, 33, "mul_post_fl");

    launch(3'b101, 32'd100, 32'd7, 1'b1, 32'd14, "ign");
    repeat (4) @(posedge clk);
    @(negedge clk);
    funct3 = 3'b000;
    a      = 32'd5;
    b      = 32'd6;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(33, 5, "ign");

    launch(3'b000, 32'd3, 32'd5, 1'b0, '0, "rm");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_busy", 32'(busy_o), 32'd0);
    chk("rm_done", 32'(done_o), 32'd0);
    chk("rm_res", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet(40, "rm");
    chk("rm_res_after", result_o, 32'd0);
    last_res = '0;

    run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
    run(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem0");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1, "div_ovf");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1, "rem_ovf");
    run(3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "divu0");
    run(3'b111, 32'd9, 32'd0, 32'd9, 1, "remu0");

    sel4 = 1'b1;
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 9, "b4_mulhu");
    run(3'b100, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 9, "b4_div");
    run(3'b110, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 9, "b4_rem");
    run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "b4_div0");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = 64'(ra) * 64'(rb);
      run(3'b011, ra, rb, p[63:32], 9, "b4_rnd_mulhu");
      run(3'b000, ra, rb, p[31:0], 9, "b4_rnd_mul");
      rb = 32'($urandom_range(1, 5000));
      run(3'b101, ra, rb, ra / rb, 9, "b4_rnd_divu");
      run(3'b111, ra, rb, ra % rb, 9, "b4_rnd_remu");
    end
    sel4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
